// File: rtl/decade_counter.sv
// decade_counter: synchronous packed-BCD counter of DIGITS decades with a
// count enable (in) and a combinational ripple-carry output (o).
// Optional feature macro: DECADE_COUNTER_CLR_EN adds a synchronous clear
// input (clr) that zeroes every digit and masks the carry output.
// Cascade stages by feeding o of one instance into in of the next.
module decade_counter #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in,
`ifdef DECADE_COUNTER_CLR_EN
    input  logic                  clr,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  o
);

    // nines_below[k] is high when every digit below k holds 9; digit k
    // advances on an enabled edge only when this is true.
    logic [DIGITS:0] nines_below;

    assign nines_below[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] digit_reg;
            logic [3:0] digit_next;
            logic       step;

            assign nines_below[gi+1] = nines_below[gi] & (digit_reg == 4'd9);
            assign step              = in & nines_below[gi];

            // Next digit value: 9 wraps to 0, and any illegal 10..15 code is
            // also sent to 0 so a corrupted digit recovers on its next step.
            always_comb begin
                digit_next = digit_reg;
                if (step) begin
                    if (digit_reg >= 4'd9)
                        digit_next = 4'd0;
                    else
                        digit_next = digit_reg + 4'd1;
                end
`ifdef DECADE_COUNTER_CLR_EN
                if (clr)
                    digit_next = 4'd0;
`endif
            end

            // Digit register with asynchronous active-low reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    digit_reg <= 4'd0;
                else
                    digit_reg <= digit_next;
            end

            assign q[4*gi +: 4] = digit_reg;
        end
    endgenerate

    // Carry out is purely combinational: enabled and the whole count at all-nines.
`ifdef DECADE_COUNTER_CLR_EN
    assign o = in & nines_below[DIGITS] & ~clr;
`else
    assign o = in & nines_below[DIGITS];
`endif

endmodule

// File: tb/tb_decade_counter.sv
// tb_decade_counter: checks a 1-digit and a 2-digit decade_counter against an
// integer reference model (count modulo 10^DIGITS, converted to BCD).
module tb_decade_counter;

`ifdef DECADE_COUNTER_CLR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in1, in2, clr1, clr2;
    logic [3:0] q1;
    logic [7:0] q2;
    logic       o1, o2;

    always #5 clk = ~clk;

    decade_counter #(.DIGITS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in1),
`ifdef DECADE_COUNTER_CLR_EN
        .clr   (clr1),
`endif
        .q     (q1),
        .o     (o1)
    );

    decade_counter #(.DIGITS(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in2),
`ifdef DECADE_COUNTER_CLR_EN
        .clr   (clr2),
`endif
        .q     (q2),
        .o     (o2)
    );

    int checks = 0;
    int errors = 0;
    int cnt1   = 0;   // reference value of dut1, 0..9
    int cnt2   = 0;   // reference value of dut2, 0..99
    logic last_o1, last_o2;

    typedef struct {
        logic       in;
        logic       exp_o;   // carry during the cycle before the edge
        logic [3:0] exp_q;   // count after the edge
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] to_bcd(int v, int nd);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check carry against the model before the
    // edge, advance the model on the edge, then check both counts.
    task automatic cycle(input logic i1, input logic i2, input logic c1, input logic c2);
        logic eo1, eo2;
        in1  = i1;
        in2  = i2;
        clr1 = c1;
        clr2 = c2;
        #1;
        eo1 = i1 && (cnt1 == 9) && !(CLR_EN && c1);
        eo2 = i2 && (cnt2 == 99) && !(CLR_EN && c2);
        check("o1", {31'b0, o1}, {31'b0, eo1});
        check("o2", {31'b0, o2}, {31'b0, eo2});
        last_o1 = o1;
        last_o2 = o2;
        @(posedge clk);
        if (CLR_EN && c1)  cnt1 = 0;
        else if (i1)       cnt1 = (cnt1 + 1) % 10;
        if (CLR_EN && c2)  cnt2 = 0;
        else if (i2)       cnt2 = (cnt2 + 1) % 100;
        #1;
        check("q1", {28'b0, q1}, to_bcd(cnt1, 1));
        check("q2", {24'b0, q2}, to_bcd(cnt2, 2));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        cnt1 = 0;
        cnt2 = 0;
        check("async_rst_q1", {28'b0, q1}, 32'h0);
        check("async_rst_q2", {24'b0, q2}, 32'h0);
        check("async_rst_o1", {31'b0, o1}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;

        // Directed vectors for DIGITS=1 starting from reset.
        tbl[0]  = '{1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 4'd1};
        tbl[2]  = '{1'b1, 1'b0, 4'd2};
        tbl[3]  = '{1'b1, 1'b0, 4'd3};
        tbl[4]  = '{1'b1, 1'b0, 4'd4};
        tbl[5]  = '{1'b1, 1'b0, 4'd5};
        tbl[6]  = '{1'b1, 1'b0, 4'd6};
        tbl[7]  = '{1'b1, 1'b0, 4'd7};
        tbl[8]  = '{1'b1, 1'b0, 4'd8};
        tbl[9]  = '{1'b1, 1'b0, 4'd9};
        tbl[10] = '{1'b1, 1'b1, 4'd0};
        tbl[11] = '{1'b1, 1'b0, 4'd1};

        // Reset held with enable high and the clock running.
        rst_n = 1'b0;
        in1 = 1'b1; in2 = 1'b1; clr1 = 1'b0; clr2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_q1", {28'b0, q1}, 32'h0);
            check("rst_q2", {24'b0, q2}, 32'h0);
            check("rst_o1", {31'b0, o1}, 32'h0);
            check("rst_o2", {31'b0, o2}, 32'h0);
        end
        in1 = 1'b0; in2 = 1'b0;
        rst_n = 1'b1;

        // Table: single step, hold and decade wrap of the 1-digit counter.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].in, 1'b0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_o", i), {31'b0, last_o1}, {31'b0, tbl[i].exp_o});
            check($sformatf("tbl%0d_q", i), {28'b0, q1}, {28'b0, tbl[i].exp_q});
            $display("vec %0d: in=%0b o=%0b q=%0d", i, tbl[i].in, last_o1, q1);
        end

        // Carry into the tens digit: 10 edges from 00 gives 10.
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("q2_carry_10", {24'b0, q2}, 32'h10);
        $display("carry: q2=%0h", q2);

        // Advance to 47 then hold for 5 edges.
        for (int i = 0; i < 37; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("q2_hold_47", {24'b0, q2}, 32'h47);
        $display("hold: q2=%0h", q2);

        // Async reset mid-count.
        reset_pulse();
        check("q2_after_rst", {24'b0, q2}, 32'h0);
        $display("async reset: q2=%0h", q2);

        // Up to 99, then the full wrap.
        for (int i = 0; i < 99; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("q2_at_99", {24'b0, q2}, 32'h99);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("o2_before_wrap", {31'b0, last_o2}, 32'h1);
        check("q2_wrap_00", {24'b0, q2}, 32'h0);
        $display("wrap: o2=%0b q2=%0h", last_o2, q2);

        // Exactly one carry pulse per 100 enabled edges.
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            if (last_o2) pulses++;
        end
        check("o2_pulses_200", 32'(pulses), 32'd2);
        $display("pulses in 200 edges: %0d", pulses);

`ifdef DECADE_COUNTER_CLR_EN
        // Clear at 9 with enable high: carry masked, count goes to 0.
        while (cnt1 != 9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("clr_o1", {31'b0, last_o1}, 32'h0);
        check("clr_q1", {28'b0, q1}, 32'h0);
        $display("clr: o1=%0b q1=%0h", last_o1, q1);
`endif

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic ri1, ri2, rc1, rc2;
            ri1 = ($urandom_range(0, 3) != 0);
            ri2 = ($urandom_range(0, 3) != 0);
            rc1 = ($urandom_range(0, 49) == 0);
            rc2 = ($urandom_range(0, 49) == 0);
            cycle(ri1, ri2, rc1, rc2);
            if ($urandom_range(0, 199) == 0) reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
